fsm_request_initiator: RTL and testbench

- Initiator side of the wr_en/rd_en request protocol served by fsm_controller.
- Accepts write/read commands over a valid/ready handshake and drives one-cycle wr_en/rd_en pulses into the controller.
- Fires a pulse only while the controller reports IDLE, then tracks the controller's state until it returns to IDLE.
- Reports completions and timeouts, and keeps per-type transaction counts.

---
 rtl/fsm_request_initiator.sv | 105 ++++++++++
 tb/tb_fsm_request_initiator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fsm_request_initiator.sv
// fsm_request_initiator: issues wr_en/rd_en pulses to fsm_controller and tracks its state back to IDLE.
// Define FSM_REQ_INITIATOR_CHECK_EN to add the sticky proto_err protocol monitor.
module fsm_request_initiator #(
  parameter logic [2:0] IDLE_CODE = 3'b000,
  parameter int         TIMEOUT   = 16,
  parameter int         CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  input  logic             cmd_is_read,
  output logic             cmd_ready,
  input  logic [2:0]       ctrl_state,
  output logic             wr_en,
  output logic             rd_en,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] wr_count,
`ifdef FSM_REQ_INITIATOR_CHECK_EN
  output logic [CNT_W-1:0] rd_count,
  output logic             proto_err
`else
  output logic [CNT_W-1:0] rd_count
`endif
);
  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_ARM         = 2'd1;
  localparam logic [1:0] S_WAIT_LEAVE  = 2'd2;
  localparam logic [1:0] S_WAIT_RETURN = 2'd3;
  logic [1:0] state;
  logic [7:0] tcnt;
  logic       is_read;
  logic       at_idle;
  logic       tmo;
  assign at_idle   = ctrl_state == IDLE_CODE;
  assign tmo       = tcnt == 8'(TIMEOUT - 1);
  assign cmd_ready = state == S_IDLE && enable;
  assign busy      = state != S_IDLE;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      is_read     <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      wr_count    <= '0;
      rd_count    <= '0;
    end else begin
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE:
          if (cmd_valid && cmd_ready) begin
            is_read <= cmd_is_read;
            state   <= S_ARM;
          end
        S_ARM:
          if (at_idle) begin
            wr_en <= !is_read;
            rd_en <= is_read;
            tcnt  <= '0;
            state <= S_WAIT_LEAVE;
          end
        S_WAIT_LEAVE:
          if (!at_idle) begin
            tcnt  <= '0;
            state <= S_WAIT_RETURN;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else tcnt <= tcnt + 8'd1;
        default:
          if (at_idle) begin
            done <= 1'b1;
            if (is_read) rd_count <= rd_count + CNT_W'(1);
            else wr_count <= wr_count + CNT_W'(1);
            state <= S_IDLE;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else tcnt <= tcnt + 8'd1;
      endcase
    end
  end
`ifdef FSM_REQ_INITIATOR_CHECK_EN
  logic [2:0] prev_ctrl;
  // tcnt==0 in S_WAIT_RETURN means the controller was away from IDLE for only one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_ctrl <= IDLE_CODE;
      proto_err <= 1'b0;
    end else begin
      prev_ctrl <= ctrl_state;
      if ((state == S_IDLE && ctrl_state != prev_ctrl) || (state == S_WAIT_RETURN && tcnt == 8'd0 && at_idle))
        proto_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fsm_request_initiator.sv
// tb_fsm_request_initiator: table-driven vectors plus directed timeout, wrap and reset sequences.
module tb_fsm_request_initiator;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_is_read = 1'b0;
  logic [2:0] ctrl_state = 3'd0;
  logic       cmd_ready, wr_en, rd_en, busy, done, timeout_err;
  logic [7:0] wr_count, rd_count;
`ifdef FSM_REQ_INITIATOR_CHECK_EN
  logic       proto_err;
`endif
  int checks = 0;
  int failures = 0;

  fsm_request_initiator dut (
    .clock(clock), .reset(reset), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_is_read(cmd_is_read), .cmd_ready(cmd_ready), .ctrl_state(ctrl_state),
    .wr_en(wr_en), .rd_en(rd_en), .busy(busy), .done(done), .timeout_err(timeout_err),
`ifdef FSM_REQ_INITIATOR_CHECK_EN
    .wr_count(wr_count), .rd_count(rd_count), .proto_err(proto_err)
`else
    .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       en, valid, rd;
    logic [2:0] ctrl;
    logic [21:0] exp;
  } vec_t;

  vec_t v[21];

  function automatic vec_t mk(logic en, logic valid, logic rd, logic [2:0] ctrl,
                              logic w, logic r, logic b, logic d, logic t, logic rdy,
                              logic [7:0] wc, logic [7:0] rc);
    vec_t x;
    x.en = en; x.valid = valid; x.rd = rd; x.ctrl = ctrl;
    x.exp = {w, r, b, d, t, rdy, wc, rc};
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] exp_wc;

  initial begin
    //            en v  rd ctrl   w  r  b  d  t  rdy wc rc
    v[0]  = mk(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 8'd0, 8'd0);
    v[1]  = mk(1, 1, 0, 3'd0, 0, 0, 1, 0, 0, 0, 8'd0, 8'd0);
    v[2]  = mk(1, 0, 0, 3'd0, 1, 0, 1, 0, 0, 0, 8'd0, 8'd0);
    v[3]  = mk(1, 0, 0, 3'd0, 0, 0, 1, 0, 0, 0, 8'd0, 8'd0);
    v[4]  = mk(1, 0, 0, 3'd1, 0, 0, 1, 0, 0, 0, 8'd0, 8'd0);
    v[5]  = mk(1, 0, 0, 3'd1, 0, 0, 1, 0, 0, 0, 8'd0, 8'd0);
    v[6]  = mk(1, 0, 0, 3'd0, 0, 0, 0, 1, 0, 1, 8'd1, 8'd0);
    v[7]  = mk(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 8'd1, 8'd0);
    v[8]  = mk(1, 1, 1, 3'd2, 0, 0, 1, 0, 0, 0, 8'd1, 8'd0);
    v[9]  = mk(1, 0, 0, 3'd2, 0, 0, 1, 0, 0, 0, 8'd1, 8'd0);
    v[10] = mk(1, 0, 0, 3'd2, 0, 0, 1, 0, 0, 0, 8'd1, 8'd0);
    v[11] = mk(1, 0, 0, 3'd2, 0, 0, 1, 0, 0, 0, 8'd1, 8'd0);
    v[12] = mk(1, 0, 0, 3'd0, 0, 1, 1, 0, 0, 0, 8'd1, 8'd0);
    v[13] = mk(1, 0, 0, 3'd3, 0, 0, 1, 0, 0, 0, 8'd1, 8'd0);
    v[14] = mk(1, 0, 0, 3'd0, 0, 0, 0, 1, 0, 1, 8'd1, 8'd1);
    v[15] = mk(1, 1, 0, 3'd0, 0, 0, 1, 0, 0, 0, 8'd1, 8'd1);
    v[16] = mk(0, 1, 1, 3'd0, 1, 0, 1, 0, 0, 0, 8'd1, 8'd1);
    v[17] = mk(0, 1, 1, 3'd5, 0, 0, 1, 0, 0, 0, 8'd1, 8'd1);
    v[18] = mk(0, 1, 1, 3'd0, 0, 0, 0, 1, 0, 0, 8'd2, 8'd1);
    v[19] = mk(0, 1, 1, 3'd0, 0, 0, 0, 0, 0, 0, 8'd2, 8'd1);
    v[20] = mk(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 8'd2, 8'd1);

    repeat (100) @(posedge clock);
    #1;
    chk("reset_hold", {wr_en, rd_en, busy, done, timeout_err, cmd_ready, wr_count, rd_count}, 22'd0);
    reset = 1'b1;
    enable = 1'b1;
    #1;
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 21; i++) begin
      enable = v[i].en; cmd_valid = v[i].valid; cmd_is_read = v[i].rd; ctrl_state = v[i].ctrl;
      tick();
      chk($sformatf("vec%0d", i), {wr_en, rd_en, busy, done, timeout_err, cmd_ready, wr_count, rd_count}, v[i].exp);
    end

    // timeout while waiting for the controller to leave IDLE
    cmd_valid = 1'b1; cmd_is_read = 1'b0; ctrl_state = 3'd0;
    tick();
    chk("to_leave_accept", busy, 1);
    cmd_valid = 1'b0;
    tick();
    chk("to_leave_pulse", wr_en, 1);
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j < 16) chk($sformatf("to_leave_quiet%0d", j), {timeout_err, busy}, 2'b01);
    end
    chk("to_leave_fire", {timeout_err, busy, cmd_ready, done, wr_count, rd_count}, {4'b1010, 8'd2, 8'd1});
    tick();
    chk("to_leave_pulse_end", timeout_err, 0);

    // timeout while waiting for the controller to return to IDLE
    cmd_valid = 1'b1; cmd_is_read = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("to_ret_pulse", {rd_en, wr_en}, 2'b10);
    ctrl_state = 3'd4;
    tick();
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j < 16) chk($sformatf("to_ret_quiet%0d", j), {timeout_err, busy}, 2'b01);
    end
    chk("to_ret_fire", {timeout_err, busy, cmd_ready, wr_count, rd_count}, {3'b101, 8'd2, 8'd1});
    ctrl_state = 3'd0;
    tick();

    // 256 back-to-back writes wrap the 8-bit counter back to its start value
    exp_wc = 8'd2;
    for (int n = 0; n < 256; n++) begin
      cmd_valid = 1'b1; cmd_is_read = 1'b0;
      tick();
      chk($sformatf("b2b_accept%0d", n), busy, 1);
      cmd_valid = 1'b0;
      tick();
      chk($sformatf("b2b_pulse%0d", n), wr_en, 1);
      ctrl_state = 3'd1;
      tick();
      ctrl_state = 3'd0;
      tick();
      exp_wc = exp_wc + 8'd1;
      chk($sformatf("b2b_done%0d", n), {done, wr_count, rd_count}, {1'b1, exp_wc, 8'd1});
    end
    chk("wrap_final", wr_count, 8'd2);

    // asynchronous reset while a pulse is in flight
    cmd_valid = 1'b1; cmd_is_read = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_pre_pulse", {wr_en, busy}, 2'b11);
    #2 reset = 1'b0;
    #1;
    chk("rst_async", {wr_en, rd_en, busy, done, timeout_err, wr_count, rd_count}, 21'd0);
    chk("rst_ready", cmd_ready, 1);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_release", {busy, cmd_ready}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
